fir_seq_ctrl: RTL and testbench

- Sequencer and tap-RAM arbiter for the FIR engine (Tape_Num taps, circular data buffer in data BRAM, taps in tap BRAM).
- Owns the ap_start/ap_done/ap_idle protocol, the AXI-Stream in/out handshakes, and all tap/data BRAM addressing.
- Drives the external MAC datapath through mac_clr/mac_en.
- Arbitrates the tap BRAM between AXI-Lite config access (idle only) and the engine.

---
 rtl/fir_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_seq_ctrl : FIR sequencer, stream handshakes and tap/data BRAM arbiter   |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start_req,
  input  logic                   ap_done_clr,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  input  logic                   cfg_tap_EN,
  input  logic [3:0]             cfg_tap_WE,
  input  logic [pADDR_WIDTH-1:0] cfg_tap_A,
  output logic                   cfg_tap_busy,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   tlast_err
);

  localparam int IW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR     = 3'd1;
  localparam logic [2:0] S_WAIT_IN = 3'd2;
  localparam logic [2:0] S_MAC     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  localparam logic [IW-1:0] LAST_IDX = IW'(Tape_Num - 1);
  localparam logic [IW:0]   TAPS_X   = (IW + 1)'(Tape_Num);

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [IW-1:0]          wp;
  logic [IW-1:0]          i;
  logic [pDATA_WIDTH-1:0] sample_cnt;
  logic [pDATA_WIDTH-1:0] cnt_inc;
  logic                   last;
  logic                   last_nxt;
  logic                   start_ok;
  logic                   accept;
  logic                   out_hs;
  logic [IW:0]            rd_idx;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IW:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign cnt_inc  = sample_cnt + pDATA_WIDTH'(1);
  assign last_nxt = (cnt_inc == data_length);
  assign start_ok = (state == S_IDLE) && ap_start_req && (data_length != '0);
  assign accept   = (state == S_WAIT_IN) && ss_tvalid;
  assign out_hs   = (state == S_OUT) && sm_tready;

  // Newest sample sits at wp; tap i pairs with the sample i slots older.
  assign rd_idx = (wp >= i) ? ({1'b0, wp} - {1'b0, i})
                            : (({1'b0, wp} + TAPS_X) - {1'b0, i});

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_CLR;
      S_CLR:     if (i == LAST_IDX) state_nxt = S_WAIT_IN;
      S_WAIT_IN: if (ss_tvalid) state_nxt = S_MAC;
      S_MAC:     if (i == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN:   state_nxt = S_OUT;
      S_OUT:     if (sm_tready) state_nxt = last ? S_IDLE : S_WAIT_IN;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wp         <= '0;
      i          <= '0;
      sample_cnt <= '0;
      last       <= 1'b0;
      ap_start   <= 1'b0;
      ap_done    <= 1'b0;
      tlast_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) i <= '0;
        S_CLR: begin
          if (i == LAST_IDX) begin
            wp         <= '0;
            sample_cnt <= '0;
            i          <= '0;
          end else begin
            i <= i + IW'(1);
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            sample_cnt <= cnt_inc;
            last       <= last_nxt;
            i          <= '0;
          end
        end
        S_MAC: if (i != LAST_IDX) i <= i + IW'(1);
        S_OUT: if (sm_tready && !last) wp <= (wp == LAST_IDX) ? '0 : wp + IW'(1);
        default: ;
      endcase

      if (start_ok)    ap_start <= 1'b1;
      else if (accept) ap_start <= 1'b0;

      // Completion outranks a coincident clear.
      if (out_hs && last)               ap_done <= 1'b1;
      else if (ap_done_clr || start_ok) ap_done <= 1'b0;

      if (start_ok)                                tlast_err <= 1'b0;
      else if (accept && (ss_tlast != last_nxt))   tlast_err <= 1'b1;
    end
  end

  always_comb begin
    ap_idle      = 1'b0;
    cfg_tap_busy = 1'b1;
    ss_tready    = 1'b0;
    sm_tvalid    = 1'b0;
    sm_tlast     = 1'b0;
    tap_EN       = 1'b0;
    tap_WE       = 4'h0;
    tap_A        = '0;
    data_EN      = 1'b0;
    data_WE      = 4'h0;
    data_A       = '0;
    data_Di      = '0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle      = 1'b1;
        cfg_tap_busy = 1'b0;
        tap_EN       = cfg_tap_EN;
        tap_WE       = cfg_tap_WE;
        tap_A        = cfg_tap_A;
      end
      S_CLR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr({1'b0, i});
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = word_addr({1'b0, wp});
          data_Di = ss_tdata;
          mac_clr = 1'b1;
        end
      end
      S_MAC: begin
        tap_EN  = 1'b1;
        tap_A   = word_addr({1'b0, i});
        data_EN = 1'b1;
        data_A  = word_addr(rd_idx);
        // Products lag addresses by one cycle of BRAM read latency.
        mac_en  = (i != '0);
      end
      S_DRAIN: mac_en = 1'b1;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_seq_ctrl : directed self-checking bench for fir_seq_ctrl             |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ap_start_req = 1'b0;
  logic        ap_done_clr = 1'b0;
  logic [31:0] data_length = '0;
  logic        ap_start, ap_done, ap_idle;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata = '0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic        sm_tready = 1'b0;
  logic        sm_tvalid, sm_tlast;
  logic        cfg_tap_EN = 1'b0;
  logic [3:0]  cfg_tap_WE = '0;
  logic [11:0] cfg_tap_A = '0;
  logic        cfg_tap_busy;
  logic        tap_EN;
  logic [3:0]  tap_WE;
  logic [11:0] tap_A;
  logic        data_EN;
  logic [3:0]  data_WE;
  logic [11:0] data_A;
  logic [31:0] data_Di;
  logic        mac_clr, mac_en, tlast_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .axis_clk(clk), .axis_rst(rst),
    .ap_start_req(ap_start_req), .ap_done_clr(ap_done_clr), .data_length(data_length),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast),
    .cfg_tap_EN(cfg_tap_EN), .cfg_tap_WE(cfg_tap_WE), .cfg_tap_A(cfg_tap_A),
    .cfg_tap_busy(cfg_tap_busy),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A),
    .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di),
    .mac_clr(mac_clr), .mac_en(mac_en), .tlast_err(tlast_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Start a run and walk the 11 buffer-clear cycles; returns in WAIT_IN.
  task automatic start_run(input logic [31:0] len);
    @(negedge clk);
    data_length  = len;
    ap_start_req = 1'b1;
    @(negedge clk);
    ap_start_req = 1'b0;
    cfg_tap_EN = 1'b1; cfg_tap_WE = 4'hF; cfg_tap_A = 12'h010;
    for (int k = 0; k < 11; k++) begin
      #1;
      check_eq("clr_A", data_A, 4 * k);
      check_eq("clr_EN_WE", {data_EN, data_WE}, 5'h1F);
      check_eq("clr_Di", data_Di, 0);
      check_eq("clr_ready", ss_tready, 0);
      if (k == 0) begin
        check_eq("clr_status", {ap_start, ap_done, ap_idle, tlast_err}, 4'b1000);
        check_eq("busy_tapWE", {cfg_tap_busy, tap_EN, tap_WE}, 6'b100000);
      end
      @(negedge clk);
    end
    cfg_tap_EN = 1'b0; cfg_tap_WE = 4'h0; cfg_tap_A = '0;
    #1;
    check_eq("wait_ready", ss_tready, 1);
    check_eq("wait_start", ap_start, 1);
  endtask

  // Push one sample and follow it through MAC, DRAIN and OUT.
  task automatic send_sample(input logic [31:0] d, input logic tl, input int wp,
                             input logic lst, input int stall, input logic done_clr);
    @(negedge clk);
    ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = tl;
    #1;
    check_eq("in_ready", ss_tready, 1);
    check_eq("in_A", data_A, 4 * wp);
    check_eq("in_Di", data_Di, d);
    check_eq("in_EN_WE_clr", {data_EN, data_WE, mac_clr}, 6'b111111);
    @(negedge clk);
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    for (int k = 0; k < 11; k++) begin
      #1;
      check_eq("mac_tapA", tap_A, 4 * k);
      check_eq("mac_dataA", data_A, 4 * ((wp - k + 11) % 11));
      check_eq("mac_en", mac_en, (k >= 1));
      check_eq("mac_ctl", {tap_EN, data_EN, data_WE, ss_tready, sm_tvalid}, 8'b11000000);
      if (k == 0) check_eq("mac_start", ap_start, 0);
      @(negedge clk);
    end
    #1;
    check_eq("drain", {mac_en, sm_tvalid, data_EN}, 3'b100);
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      #1;
      check_eq("stall_out", {sm_tvalid, sm_tlast, ss_tready}, {1'b1, lst, 1'b0});
      @(negedge clk);
    end
    sm_tready = 1'b1; ap_done_clr = done_clr;
    #1;
    check_eq("out", {sm_tvalid, sm_tlast, mac_en}, {1'b1, lst, 1'b0});
    @(negedge clk);
    sm_tready = 1'b0; ap_done_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_status", {ap_idle, ap_start, ap_done, tlast_err, cfg_tap_busy}, 5'b10000);
    check_eq("rst_bram", {tap_EN, tap_WE, tap_A, data_EN, data_WE, data_A, data_Di}, 0);
    check_eq("rst_stream", {ss_tready, sm_tvalid, sm_tlast, mac_clr, mac_en}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-length start is ignored; config passes through while idle.
    @(negedge clk);
    data_length = 0; ap_start_req = 1'b1;
    @(negedge clk);
    ap_start_req = 1'b0;
    cfg_tap_EN = 1'b1; cfg_tap_WE = 4'hF; cfg_tap_A = 12'h014;
    #1;
    check_eq("len0_status", {ap_idle, ap_start, ap_done, ss_tready}, 4'b1000);
    check_eq("idle_cfg", {cfg_tap_busy, tap_EN, tap_WE, tap_A}, {1'b0, 1'b1, 4'hF, 12'h014});
    cfg_tap_EN = 1'b0; cfg_tap_WE = 4'h0; cfg_tap_A = '0;

    // Run 1: three samples, stall on the second, done_clr on the final handshake.
    start_run(3);
    send_sample(32'h11, 1'b0, 0, 1'b0, 0, 1'b0);
    send_sample(32'h22, 1'b0, 1, 1'b0, 5, 1'b0);
    send_sample(32'h33, 1'b1, 2, 1'b1, 0, 1'b1);
    #1;
    check_eq("run1_end", {ap_done, ap_idle, ap_start, tlast_err, ss_tready}, 5'b11000);

    // Run 2: twelve samples wrap the write pointer; early tlast on sample 10.
    start_run(12);
    for (int s = 0; s < 12; s++) begin
      send_sample(32'h100 + s, (s == 9), s % 11, (s == 11), 0, 1'b0);
      #1;
      if (s < 11) check_eq("run2_wait", {ss_tready, ap_done, ap_idle}, 3'b100);
      else        check_eq("run2_end", {ap_done, ap_idle, sm_tvalid}, 3'b110);
      if (s == 8) check_eq("tlast_err_pre", tlast_err, 0);
      if (s == 9) check_eq("tlast_err_set", tlast_err, 1);
      if (s == 4) begin
        ap_start_req = 1'b1;
        @(negedge clk);
        ap_start_req = 1'b0;
        #1;
        check_eq("busy_start", {ap_start, ss_tready, ap_idle}, 3'b010);
      end
    end
    @(negedge clk);
    ap_done_clr = 1'b1;
    @(negedge clk);
    ap_done_clr = 1'b0;
    #1;
    check_eq("done_clr", {ap_done, tlast_err}, 2'b01);

    // Run 3: reset in the middle of MAC, then a fresh one-sample run.
    start_run(5);
    @(negedge clk);
    ss_tvalid = 1'b1; ss_tdata = 32'h7;
    @(negedge clk);
    ss_tvalid = 1'b0; ss_tdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_rst_mac", mac_en, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst_status", {ap_idle, ap_start, ap_done, tlast_err, cfg_tap_busy}, 5'b10000);
    check_eq("midrst_bram", {tap_EN, tap_WE, tap_A, data_EN, data_WE, data_A, data_Di}, 0);
    check_eq("midrst_stream", {ss_tready, sm_tvalid, sm_tlast, mac_clr, mac_en}, 0);
    rst = 1'b0;
    start_run(1);
    send_sample(32'h5, 1'b1, 0, 1'b1, 0, 1'b0);
    #1;
    check_eq("run3_end", {ap_done, ap_idle, tlast_err}, 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
